instr_mem_prog: RTL
===================

// Module: instr_mem_prog
// PURPOSE
//  Parametrised, word-addressed instruction memory for the CPU fetch stage.
//  Replaces the hard-coded program image with a run-time load port. Adds a
//  post-reset clear sweep, a registered fetch port with range checking and
//  a LOAD/RUN mode FSM. Sits between the PC/fetch logic and the boot/host
//  loader.
// PARAMETERS
//  DATA_WIDTH  32            instruction word width (bits)
//  DEPTH       1024          number of words; word address range 0..DEPTH-1
//  ADDR_WIDTH  32            width of fetch_addr and prog_addr
//  NOP_WORD    {5'd0,27'd0}  value written by the clear sweep; returned on fault
// PORTS
//  clock        in   1           single clock, all logic on rising edge
//  reset        in   1           synchronous, active-low
//  fetch_req    in   1           fetch request, sampled when fetch_ready=1
//  fetch_addr   in   ADDR_WIDTH  word address of requested instruction
//  fetch_ready  out  1           1 only in RUN state
//  fetch_valid  out  1           response strobe, 1 cycle after accepted req
//  fetch_instr  out  DATA_WIDTH  instruction word, valid with fetch_valid
//  fetch_fault  out  1           with fetch_valid: fetch_addr was >= DEPTH
//  prog_start   in   1           RUN->LOAD request (1-cycle pulse)
//  prog_valid   in   1           load word present
//  prog_addr    in   ADDR_WIDTH  load destination word address
//  prog_data    in   DATA_WIDTH  load word
//  prog_last    in   1           marks final load word
//  prog_ready   out  1           1 only in LOAD state
//  prog_err     out  1           1-cycle pulse: accepted load word with addr >= DEPTH
//  prog_count   out  clog2(DEPTH+1)  words written in current LOAD session
// BEHAVIOUR
//  Reset (reset==0 at posedge): state=CLEAR, clear index=0, fetch_valid=0,
//   fetch_fault=0, fetch_instr=NOP_WORD, prog_ready=0, prog_err=0,
//   prog_count=0. Memory contents are not reset directly; the sweep clears them.
//  FSM: CLEAR -> LOAD -> RUN -> (prog_start) LOAD -> ...
//   CLEAR: writes NOP_WORD to mem[idx] each cycle, idx 0..DEPTH-1 (DEPTH
//    cycles). Enters LOAD after idx==DEPTH-1. Fetch and prog inputs are ignored.
//   LOAD: prog_ready=1. Word accepted when prog_valid&&prog_ready.
//    addr<DEPTH: mem[addr]<=prog_data, prog_count++ (saturates at DEPTH).
//    addr>=DEPTH: write dropped, prog_err pulses next cycle, no count.
//    Accepted word with prog_last=1 -> RUN next cycle (written if in range).
//    A later write to the same address overwrites the earlier one.
//   RUN: fetch_ready=1. Accepted req -> next cycle fetch_valid=1 and
//    fetch_instr=mem[fetch_addr], fetch_fault=0. If addr>=DEPTH:
//    fetch_instr=NOP_WORD, fetch_fault=1. Back-to-back reqs give one
//    response per cycle, in order. With no req, fetch_valid=0 and
//    fetch_instr/fetch_fault hold their last values.
//    prog_start=1 -> LOAD next cycle, prog_count cleared to 0. A fetch
//    accepted in that same cycle still returns its response next cycle.
//    No clear sweep on re-load.
//  prog_start outside RUN is ignored. prog_valid outside LOAD is dropped
//   (no err pulse).
//  Address compare uses the full ADDR_WIDTH value; no truncation or wrap.
//  Reset asserted mid-CLEAR/LOAD/RUN: restarts at CLEAR. An in-flight fetch
//   response is suppressed (fetch_valid=0 in the cycle after reset).
// TESTING (DEPTH=8, DATA_WIDTH=32 unless noted)
//  1 Release reset -> fetch_ready=0 and prog_ready=0 for 8 cycles, then
//    prog_ready=1. Load a single word (addr 0, prog_last=1), then fetch
//    addrs 1..7 -> each returns NOP_WORD, fault=0.
//  2 LOAD {0:0xC8800032, 1:0xC880000A, 2:0x08...} with prog_valid gaps;
//    last on word 2 -> prog_count=3, RUN 1 cycle after last. Fetch 0,1,2
//    back-to-back -> 3 consecutive fetch_valid with matching words.
//  3 In RUN, fetch addr 8 and addr 0xFFFF_FFFF -> fetch_valid=1,
//    fetch_fault=1, instr=NOP_WORD. Fetch addr 7 -> fault=0.
//  4 In LOAD, prog_addr=9 accepted -> prog_err pulses 1 cycle, prog_count
//    unchanged, no memory word changes.
//  5 In RUN, fetch addr 1 together with prog_start -> response valid next
//    cycle (0xC880000A). prog_ready=1 and prog_count=0 in that cycle.
//    Overwrite addr 1, last -> RUN; refetch returns the new word.
//  6 Assert reset mid-LOAD, and again the cycle after a fetch is accepted ->
//    state CLEAR, no stray fetch_valid, full 8-cycle sweep, then all 8 words
//    read NOP_WORD.

Source files
------------

// File: rtl/instr_mem_prog.sv
// instr_mem_prog
//   Word-addressed instruction memory with a run-time load port.
//   After reset the whole array is swept to NOP_WORD (CLEAR), the loader
//   then streams words in (LOAD), and the fetch port serves reads (RUN).
//   The fetch response is registered: one response per accepted request,
//   one cycle later, in order.
// Ports
//   clock, reset             : single rising-edge clock, synchronous active-low reset
//   fetch_req/addr/ready     : fetch request handshake (ready only in RUN)
//   fetch_valid/instr/fault  : registered fetch response
//   prog_start               : RUN -> LOAD request
//   prog_valid/addr/data/last/ready : load stream handshake (ready only in LOAD)
//   prog_err                 : pulse for an accepted out-of-range load word
//   prog_count               : words written in the current LOAD session
module instr_mem_prog #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD = {5'd0, 27'd0},
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_ready,
  output logic                  fetch_valid,
  output logic [DATA_WIDTH-1:0] fetch_instr,
  output logic                  fetch_fault,
  input  logic                  prog_start,
  input  logic                  prog_valid,
  input  logic [ADDR_WIDTH-1:0] prog_addr,
  input  logic [DATA_WIDTH-1:0] prog_data,
  input  logic                  prog_last,
  output logic                  prog_ready,
  output logic                  prog_err,
  output logic [CNT_W-1:0]      prog_count
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  // Full-width compare: addresses above DEPTH never alias onto low words.
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    in_range = (a < ADDR_WIDTH'(DEPTH));
  endfunction

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      clr_idx_q, clr_idx_d;
  logic                  fetch_valid_q, fetch_valid_d;
  logic [DATA_WIDTH-1:0] fetch_instr_q, fetch_instr_d;
  logic                  fetch_fault_q, fetch_fault_d;
  logic                  prog_err_q, prog_err_d;
  logic [CNT_W-1:0]      prog_count_q, prog_count_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  mem_we_s;
  logic [IDX_W-1:0]      mem_waddr_s;
  logic [DATA_WIDTH-1:0] mem_wdata_s;

  // Next-state, write-port and response computation.
  always_comb begin
    state_d       = state_q;
    clr_idx_d     = clr_idx_q;
    fetch_valid_d = 1'b0;
    fetch_instr_d = fetch_instr_q;
    fetch_fault_d = fetch_fault_q;
    prog_err_d    = 1'b0;
    prog_count_d  = prog_count_q;
    mem_we_s      = 1'b0;
    mem_waddr_s   = '0;
    mem_wdata_s   = NOP_WORD;

    case (state_q)
      ST_CLEAR: begin
        mem_we_s    = 1'b1;
        mem_waddr_s = clr_idx_q;
        mem_wdata_s = NOP_WORD;
        if (clr_idx_q == IDX_W'(DEPTH - 1)) begin
          clr_idx_d = '0;
          state_d   = ST_LOAD;
        end else begin
          clr_idx_d = clr_idx_q + IDX_W'(1);
        end
      end
      ST_LOAD: begin
        if (prog_valid) begin
          if (in_range(prog_addr)) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = prog_addr[IDX_W-1:0];
            mem_wdata_s = prog_data;
            if (prog_count_q != CNT_W'(DEPTH)) begin
              prog_count_d = prog_count_q + CNT_W'(1);
            end else begin
              prog_count_d = prog_count_q;
            end
          end else begin
            prog_err_d = 1'b1;
          end
          if (prog_last) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_RUN: begin
        if (fetch_req) begin
          fetch_valid_d = 1'b1;
          if (in_range(fetch_addr)) begin
            fetch_instr_d = mem_q[fetch_addr[IDX_W-1:0]];
            fetch_fault_d = 1'b0;
          end else begin
            fetch_instr_d = NOP_WORD;
            fetch_fault_d = 1'b1;
          end
        end else begin
          fetch_valid_d = 1'b0;
        end
        // Re-load keeps the existing image; no sweep on this path.
        if (prog_start) begin
          state_d      = ST_LOAD;
          prog_count_d = '0;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d   = ST_CLEAR;
        clr_idx_d = '0;
      end
    endcase
  end

  // Control and response registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= ST_CLEAR;
      clr_idx_q     <= '0;
      fetch_valid_q <= 1'b0;
      fetch_instr_q <= NOP_WORD;
      fetch_fault_q <= 1'b0;
      prog_err_q    <= 1'b0;
      prog_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      clr_idx_q     <= clr_idx_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_instr_q <= fetch_instr_d;
      fetch_fault_q <= fetch_fault_d;
      prog_err_q    <= prog_err_d;
      prog_count_q  <= prog_count_d;
    end
  end

  // Storage array: not reset, contents are initialised by the CLEAR sweep.
  always_ff @(posedge clock) begin
    if (reset && mem_we_s) begin
      mem_q[mem_waddr_s] <= mem_wdata_s;
    end
  end

  assign fetch_ready = (state_q == ST_RUN);
  assign prog_ready  = (state_q == ST_LOAD);
  assign fetch_valid = fetch_valid_q;
  assign fetch_instr = fetch_instr_q;
  assign fetch_fault = fetch_fault_q;
  assign prog_err    = prog_err_q;
  assign prog_count  = prog_count_q;

endmodule
